// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised circular-buffer FIFO.
// Width derivation and parameter legality checks used at elaboration time.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Never returns 0, so a degenerate size still yields a legal vector width.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2_safe(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2_safe(depth + 1);
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned af_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one registered read port.
// Only the read-data register is reset; the storage array is left uninitialised.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A same-edge write to rd_addr is not visible here: the old word is returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_queue.sv
// Parametrised circular-buffer FIFO with occupancy count, almost-full threshold,
// registered read-valid strobe and sticky overflow/underflow flags.
module fifo_queue
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enqueue,
  input  logic                       dequeue,
  input  logic                       peek,
  input  logic                       clear_err,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       is_empty,
  output logic                       is_full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_LEVEL);

  if (!params_ok(DEPTH, AF_LEVEL)) begin : g_param_check
    $error("fifo_queue: DEPTH must be a power of two >= 2 and AF_LEVEL in 1..DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q;
  logic             is_empty_q, is_full_q, almost_full_q;
  logic             overflow_q, underflow_q;
  logic             e_ok, d_ok, p_ok, rd_en;
  logic             ovf_evt, unf_evt;

  // All decisions use the registered status from the start of the cycle.
  always_comb begin
    e_ok    = enqueue & (~is_full_q | dequeue);
    d_ok    = dequeue & ~is_empty_q;
    p_ok    = peek & ~dequeue & ~is_empty_q;
    rd_en   = d_ok | p_ok;
    ovf_evt = enqueue & is_full_q & ~dequeue;
    unf_evt = (dequeue | peek) & is_empty_q;
  end

  always_comb begin
    count_d = count_q;
    if (e_ok && !d_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (d_ok && !e_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      is_empty_q    <= 1'b1;
      is_full_q     <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      if (e_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (d_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q       <= count_d;
      out_valid_q   <= rd_en;
      is_empty_q    <= (count_d == '0);
      is_full_q     <= (count_d == DepthCnt);
      almost_full_q <= (count_d >= AfCnt);
      // A new error event outranks a coincident clear.
      overflow_q    <= ovf_evt | (overflow_q & ~clear_err);
      underflow_q   <= unf_evt | (underflow_q & ~clear_err);
    end
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (e_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign is_empty    = is_empty_q;
  assign is_full     = is_full_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_queue.sv
// Self-checking bench for fifo_queue (WIDTH=8, DEPTH=8, AF_LEVEL=6) using a
// scoreboard queue of expected words filled on accepted enqueues.
module tb_fifo_queue;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AF_LEVEL = 6;

  logic             clk;
  logic             rst;
  logic             enqueue;
  logic             dequeue;
  logic             peek;
  logic             clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [3:0]       count;
  logic             is_empty;
  logic             is_full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_rd;
  logic             exp_valid;
  logic             exp_ovf;
  logic             exp_unf;

  fifo_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enqueue     (enqueue),
    .dequeue     (dequeue),
    .peek        (peek),
    .clear_err   (clear_err),
    .data_in     (data_in),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .count       (count),
    .is_empty    (is_empty),
    .is_full     (is_full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of stimulus and advances the scoreboard model.
  task automatic do_op(input logic enq, input logic deq, input logic pk, input logic clr,
                       input logic [WIDTH-1:0] din);
    int   mc;
    logic e_ok, d_ok, p_ok;
    mc   = exp_q.size();
    e_ok = enq && ((mc < DEPTH) || deq);
    d_ok = deq && (mc > 0);
    p_ok = pk && !deq && (mc > 0);
    if (enq && (mc == DEPTH) && !deq) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    if ((deq || pk) && (mc == 0)) exp_unf = 1'b1;
    else if (clr) exp_unf = 1'b0;
    if (d_ok) exp_rd = exp_q.pop_front();
    else if (p_ok) exp_rd = exp_q[0];
    exp_valid = d_ok || p_ok;
    if (e_ok) exp_q.push_back(din);
    enqueue   = enq;
    dequeue   = deq;
    peek      = pk;
    clear_err = clr;
    data_in   = din;
    @(posedge clk);
    #1;
    enqueue   = 1'b0;
    dequeue   = 1'b0;
    peek      = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_rd    = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    total++;
    if (count !== 4'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if ({is_empty, is_full, almost_full} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got=%b want=100", {is_empty, is_full, almost_full});
    end
    total++;
    if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_data got=%h/%b want=00/0", data_out, out_valid);
    end
    total++;
    if ({overflow, underflow} !== 2'b00) begin
      bad++; $display("FAIL reset_err got=%b want=00", {overflow, underflow});
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (count !== 4'd0 || is_empty !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_state got=%0d/%b/%b want=0/1/0", count, is_empty, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
      total++;
      if (count !== 4'(i + 1) || almost_full !== ((i + 1) >= AF_LEVEL)) begin
        bad++;
        $display("FAIL fill_step%0d got=%0d/%b want=%0d/%b", i, count, almost_full, i + 1,
                 (i + 1) >= AF_LEVEL);
      end
    end
    total++;
    if (is_full !== 1'b1 || is_empty !== 1'b0) begin
      bad++; $display("FAIL fill_full got=%b/%b want=1/0", is_full, is_empty);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++;
      if (out_valid !== 1'b1 || data_out !== exp_rd || data_out !== 8'(8'h10 + i)) begin
        bad++;
        $display("FAIL drain%0d got=%h/%b want=%h/1", i, data_out, out_valid, 8'(8'h10 + i));
      end
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (is_empty !== 1'b1 || count !== 4'd0 || out_valid !== 1'b0 || data_out !== 8'h17) begin
      bad++;
      $display("FAIL drain_end got=%b/%0d/%b/%h want=1/0/0/17", is_empty, count, out_valid,
               data_out);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 1));
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++;
      if (data_out !== exp_rd || out_valid !== exp_valid) begin
        bad++; $display("FAIL wrap_pre%0d got=%h want=%h", i, data_out, exp_rd);
      end
    end
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hA0 + i));
    total++;
    if (is_full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
      bad++; $display("FAIL wrap_full got=%b/%0d/%b want=1/8/0", is_full, count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++;
      if (data_out !== exp_rd || data_out !== 8'(8'hA0 + i) || out_valid !== 1'b1) begin
        bad++; $display("FAIL wrap%0d got=%h want=%h", i, data_out, 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1);
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    total++;
    if (data_out !== 8'h10 || out_valid !== 1'b1 || count !== 4'd8 || overflow !== 1'b0 ||
        is_full !== 1'b1) begin
      bad++;
      $display("FAIL simul_full got=%h/%b/%0d/%b want=10/1/8/0", data_out, out_valid, count,
               overflow);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++;
      if (data_out !== exp_rd || out_valid !== 1'b1) begin
        bad++; $display("FAIL simul_drain%0d got=%h want=%h", i, data_out, exp_rd);
      end
    end
    total++;
    if (data_out !== 8'h55) begin
      bad++; $display("FAIL simul_eighth got=%h want=55", data_out);
    end
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    total++;
    if (count !== 4'd1 || underflow !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h55) begin
      bad++;
      $display("FAIL simul_empty got=%0d/%b/%b/%h want=1/1/0/55", count, underflow, out_valid,
               data_out);
    end
    // Clear coinciding with a fresh underflow must leave the flag set.
    do_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    do_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    total++;
    if (underflow !== exp_unf || underflow !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL clear_vs_event got=%b/%b want=1/0", underflow, out_valid);
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    total++;
    if (underflow !== 1'b0) begin
      bad++; $display("FAIL clear_unf got=%b want=0", underflow);
    end
  endtask

  task automatic test_errors_peek();
    do_reset(1);
    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    total++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL overflow got=%b/%0d want=1/8", overflow, count);
    end
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    total++;
    if (data_out !== 8'h10 || out_valid !== 1'b1 || count !== 4'd8) begin
      bad++; $display("FAIL peek got=%h/%b/%0d want=10/1/8", data_out, out_valid, count);
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++;
    if (out_valid !== 1'b0 || data_out !== 8'h10 || overflow !== 1'b1) begin
      bad++; $display("FAIL peek_hold got=%b/%h/%b want=0/10/1", out_valid, data_out, overflow);
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL clear_ovf got=%b want=0", overflow);
    end
    // Dequeue outranks a simultaneous peek and must advance the head.
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    total++;
    if (data_out !== 8'h10 || count !== 4'd7) begin
      bad++; $display("FAIL deq_over_peek got=%h/%0d want=10/7", data_out, count);
    end
    for (int i = 1; i < 8; i++) begin
      do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      total++;
      if (data_out !== exp_rd || data_out !== 8'(8'h10 + i)) begin
        bad++; $display("FAIL ovf_contents%0d got=%h want=%h", i, data_out, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h63);
    total++;
    if (count !== 4'd3) begin
      bad++; $display("FAIL pre_reset_count got=%0d want=3", count);
    end
    // Reset coinciding with an enqueue must win.
    rst     = 1'b1;
    enqueue = 1'b1;
    data_in = 8'h77;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    enqueue = 1'b0;
    exp_q.delete();
    total++;
    if (count !== 4'd0 || {is_empty, is_full, almost_full} !== 3'b100 ||
        {overflow, underflow, out_valid} !== 3'b000 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got=%0d/%b/%b/%h want=0/100/000/00", count,
               {is_empty, is_full, almost_full}, {overflow, underflow, out_valid}, data_out);
    end
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    total++;
    if (underflow !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_empty got=%b/%b want=1/0", underflow, out_valid);
    end
  endtask

  initial begin
    rst       = 1'b0;
    enqueue   = 1'b0;
    dequeue   = 1'b0;
    peek      = 1'b0;
    clear_err = 1'b0;
    data_in   = '0;
    exp_rd    = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_errors_peek();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_queue.md
Name: fifo_queue

Overview:
- Parametrised circular-buffer FIFO. Generalises the team's fixed 8x8 shift-register queue to any data width and any power-of-two depth.
- Adds the following over the fixed queue:
  - simultaneous enqueue/dequeue in one cycle
  - an occupancy count
  - an almost-full threshold
  - a registered read-data valid strobe
  - sticky overflow/underflow error flags
- Sits between producer and consumer blocks in the mini-components library as the standard buffering element.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- enqueue  in  1  write request.
- dequeue  in  1  read-and-remove request.
- peek  in  1  read head without removing.
- clear_err  in  1  clears sticky error flags.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered read data.
- out_valid  out  1  data_out updated this cycle (1-cycle pulse).
- count  out  $clog2(DEPTH+1)  current occupancy.
- is_empty  out  1  count==0.
- is_full  out  1  count==DEPTH.
- almost_full  out  1  count>=AF_LEVEL.
- overflow  out  1  sticky: enqueue attempted while full with no dequeue.
- underflow  out  1  sticky: dequeue/peek attempted while empty.

Behaviour:
- Reset (single clock, synchronous, active-high; rst sampled on rising clk):
  - wr_ptr=0, rd_ptr=0, count=0
  - data_out=0, out_valid=0
  - is_empty=1, is_full=0, almost_full=0 (1 only if AF_LEVEL==0, which is disallowed)
  - overflow=0, underflow=0
  - Memory contents are not cleared.
  - Reset wins over every other input in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count is tracked separately; full/empty derive from count, never from pointer equality alone.
- Decisions use state at the start of the cycle: e_ok = enqueue & (!is_full | dequeue); d_ok = dequeue & !is_empty.
- Enqueue (e_ok): mem[wr_ptr]<=data_in; wr_ptr++.
- Dequeue (d_ok): data_out<=mem[rd_ptr]; rd_ptr++; out_valid=1 next cycle.
- Peek (peek & !dequeue & !is_empty): data_out<=mem[rd_ptr]; out_valid=1; pointers unchanged.
- Dequeue has priority over peek when both are asserted.
- Read latency: data is visible on data_out and out_valid in the cycle after the request edge. When no read occurs, out_valid=0 and data_out holds its last value.
- count update: +1 if e_ok & !d_ok; -1 if d_ok & !e_ok; otherwise unchanged.
- Status flags (is_empty, is_full, almost_full) are registered and reflect the post-update count in the same cycle count changes.
- Simultaneous enqueue+dequeue:
  - When full: both accepted; count stays DEPTH; no overflow.
  - When empty: the enqueue is accepted, the dequeue is refused, underflow sets, out_valid=0. There is no fall-through bypass.
- Overflow: enqueue & is_full & !dequeue sets overflow; the write is dropped and memory is unchanged.
- Underflow: (dequeue | peek) & is_empty sets underflow; data_out is unchanged.
- Error flags stay set until clear_err or rst. If clear_err coincides with a new error event, the new event wins and the flag stays 1.
- No combinational path from any input to any output.

Decomposition:
- Shared package fifo_pkg holds:
  - function clog2_safe
  - localparam-derived widths PTR_W and CNT_W
  - an elaboration-time check that DEPTH is a power of two and AF_LEVEL is in range.
- One natural sub-module, fifo_mem: a simple dual-port register array with one synchronous write port and one synchronous read port.
- Control (pointers, count, flags, errors) stays in fifo_queue.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, is_empty=1, is_full=0, almost_full=0, data_out=0, overflow=underflow=0.
- Fill and drain, WIDTH=8, DEPTH=8:
  - Enqueue 0x10..0x17 over 8 cycles -> count=8, is_full=1; almost_full asserted once count reached 6.
  - Dequeue 8 times -> data_out 0x10..0x17 in order, each with out_valid 1 cycle after its request; is_empty=1 at the end.
- Wrap-around:
  - Enqueue 5, dequeue 5, then enqueue 0xA0..0xA7 -> all accepted; dequeues return 0xA0..0xA7 in order across the pointer wrap.
- Simultaneous ops:
  - Full queue holding 0x10..0x17; enqueue 0x55 with dequeue -> data_out=0x10, count stays 8, no overflow; 0x55 emerges eighth.
  - Empty queue; enqueue 0x33 with dequeue -> count=1, underflow=1, out_valid=0.
- Errors and peek:
  - Full queue, enqueue 0xFF -> overflow=1, contents unchanged.
  - Peek on head 0x10 -> data_out=0x10, out_valid=1, count unchanged.
  - clear_err -> overflow=0.
  - Assert rst mid-fill (count=3) -> count=0 next cycle, all flags at reset values.
